// File: rtl/fp_add_preparer_pipe.sv
// rtl/fp_add_preparer_pipe.sv - pipelined FP-add operand preparer (classify, order, align)
//
// Purpose: decodes two IEEE-754-style operands, orders them by magnitude,
// aligns the smaller mantissa to the larger exponent and resolves NaN/inf
// special cases, ready for a mantissa adder/normaliser. Two register stages
// with a valid/ready handshake, one operation per cycle.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     input handshake for op_1, op_2, sub
//   op_1, op_2            operands {sign, exponent, fraction}
//   sub                   1: op_1 - op_2 (op_2 sign flipped)
//   out_valid/out_ready   output handshake for all result fields
//   NaN_res, inf_res      special-case results; legal = neither
//   res_sig, eff_sub      result sign, effective subtraction
//   exp_max               effective exponent of the larger operand
//   mant_big, mant_small  prepared mantissas, mant_small aligned
//   sticky                OR of bits shifted out of mant_small

module fp_add_preparer_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+MAN_W:0]     op_1,
  input  logic [EXP_W+MAN_W:0]     op_2,
  input  logic                     sub,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     NaN_res,
  output logic                     inf_res,
  output logic                     legal,
  output logic                     res_sig,
  output logic                     eff_sub,
  output logic [EXP_W-1:0]         exp_max,
  output logic [2*(MAN_W+1):0]     mant_big,
  output logic [2*(MAN_W+1):0]     mant_small,
  output logic                     sticky
);

  localparam int MW = 2*(MAN_W+1)+1;
  localparam int W  = 1+EXP_W+MAN_W;

  // Handshake: a stage loads when empty or when it drains the same cycle.
  logic s1_valid;
  logic s1_load;
  logic s2_load;

  assign s2_load  = ~out_valid | out_ready;
  assign s1_load  = ~s1_valid | s2_load;
  assign in_ready = rst_n & s1_load;

  // ---------------- S1: decode / classify / compare ----------------
  logic             a_s, b_s;
  logic [EXP_W-1:0] a_e, b_e;
  logic [MAN_W-1:0] a_f, b_f;
  logic             a_nan, b_nan, a_inf, b_inf;
  logic             a_hid, b_hid;
  logic [EXP_W-1:0] a_eff, b_eff;
  logic [EXP_W+MAN_W:0] a_mag, b_mag;
  logic             a_is_big;

  assign a_s = op_1[W-1];
  assign a_e = op_1[W-2:MAN_W];
  assign a_f = op_1[MAN_W-1:0];
  assign b_s = op_2[W-1] ^ sub;
  assign b_e = op_2[W-2:MAN_W];
  assign b_f = op_2[MAN_W-1:0];

  assign a_nan = (&a_e) & (|a_f);
  assign a_inf = (&a_e) & ~(|a_f);
  assign b_nan = (&b_e) & (|b_f);
  assign b_inf = (&b_e) & ~(|b_f);

  // Denormals (including zero) have no hidden bit and sit at exponent 1.
  assign a_hid = |a_e;
  assign b_hid = |b_e;
  assign a_eff = a_hid ? a_e : EXP_W'(1);
  assign b_eff = b_hid ? b_e : EXP_W'(1);

  assign a_mag    = {a_eff, a_hid, a_f};
  assign b_mag    = {b_eff, b_hid, b_f};
  assign a_is_big = (a_mag >= b_mag);  // ties resolve to op_1

  logic             s1_any_nan, s1_a_inf, s1_b_inf;
  logic             s1_a_s, s1_b_s, s1_big_s, s1_mag_eq;
  logic [EXP_W-1:0] s1_exp_big, s1_del;
  logic [MAN_W:0]   s1_man_big, s1_man_small;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid     <= 1'b0;
      s1_any_nan   <= 1'b0;
      s1_a_inf     <= 1'b0;
      s1_b_inf     <= 1'b0;
      s1_a_s       <= 1'b0;
      s1_b_s       <= 1'b0;
      s1_big_s     <= 1'b0;
      s1_mag_eq    <= 1'b0;
      s1_exp_big   <= '0;
      s1_del       <= '0;
      s1_man_big   <= '0;
      s1_man_small <= '0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_any_nan   <= a_nan | b_nan;
        s1_a_inf     <= a_inf;
        s1_b_inf     <= b_inf;
        s1_a_s       <= a_s;
        s1_b_s       <= b_s;
        s1_big_s     <= a_is_big ? a_s : b_s;
        s1_mag_eq    <= (a_mag == b_mag);
        s1_exp_big   <= a_is_big ? a_eff : b_eff;
        s1_del       <= a_is_big ? (a_eff - b_eff) : (b_eff - a_eff);
        s1_man_big   <= a_is_big ? {a_hid, a_f} : {b_hid, b_f};
        s1_man_small <= a_is_big ? {b_hid, b_f} : {a_hid, a_f};
      end
    end
  end

  // ---------------- S2: align / special cases ----------------
  logic [MW-1:0] full_big, full_small, shifted, lost_mask;
  logic          eff_sub_c, nan_c, inf_c, legal_c, sign_c, sticky_c;

  assign full_big   = {1'b0, s1_man_big,   {(MAN_W+1){1'b0}}};
  assign full_small = {1'b0, s1_man_small, {(MAN_W+1){1'b0}}};

  // Shifts by del >= MW give zero in both directions, so the shifted value
  // becomes 0 and the mask covers every bit: no separate saturation needed.
  assign shifted   = full_small >> s1_del;
  assign lost_mask = ~({MW{1'b1}} << s1_del);
  assign sticky_c  = |(full_small & lost_mask);

  assign eff_sub_c = s1_a_s ^ s1_b_s;
  assign nan_c     = s1_any_nan | (s1_a_inf & s1_b_inf & eff_sub_c);
  assign inf_c     = ~nan_c & (s1_a_inf | s1_b_inf);
  assign legal_c   = ~nan_c & ~inf_c;

  always_comb begin
    sign_c = 1'b0;
    if (inf_c)
      sign_c = s1_a_inf ? s1_a_s : s1_b_s;
    else if (legal_c)
      // x - x rounds to +0 under round-to-nearest.
      sign_c = (s1_mag_eq & eff_sub_c) ? 1'b0 : s1_big_s;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      NaN_res    <= 1'b0;
      inf_res    <= 1'b0;
      legal      <= 1'b0;
      res_sig    <= 1'b0;
      eff_sub    <= 1'b0;
      exp_max    <= '0;
      mant_big   <= '0;
      mant_small <= '0;
      sticky     <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        NaN_res    <= nan_c;
        inf_res    <= inf_c;
        legal      <= legal_c;
        res_sig    <= sign_c;
        eff_sub    <= eff_sub_c;
        exp_max    <= legal_c ? s1_exp_big : {EXP_W{1'b1}};
        mant_big   <= legal_c ? full_big : '0;
        mant_small <= legal_c ? shifted : '0;
        sticky     <= legal_c & sticky_c;
      end
    end
  end

endmodule

// File: tb/tb_fp_add_preparer_pipe.sv
// tb/tb_fp_add_preparer_pipe.sv - self-checking bench for fp_add_preparer_pipe

module tb_fp_add_preparer_pipe;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  op_1, op_2;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic         NaN_res, inf_res, legal, res_sig, eff_sub, sticky;
  logic [7:0]   exp_max;
  logic [48:0]  mant_big, mant_small;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fp_add_preparer_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_1(op_1), .op_2(op_2), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .NaN_res(NaN_res), .inf_res(inf_res), .legal(legal), .res_sig(res_sig),
    .eff_sub(eff_sub), .exp_max(exp_max), .mant_big(mant_big),
    .mant_small(mant_small), .sticky(sticky)
  );

  wire [111:0] obs = {NaN_res, inf_res, legal, res_sig, eff_sub, exp_max,
                      mant_big, mant_small, sticky};

  function automatic logic [111:0] pack(input logic n, input logic i, input logic l,
                                        input logic s, input logic e, input logic [7:0] x,
                                        input logic [48:0] mb, input logic [48:0] ms,
                                        input logic st);
    return {n, i, l, s, e, x, mb, ms, st};
  endfunction

  typedef struct {
    logic [31:0]  a;
    logic [31:0]  b;
    logic         s;
    logic [111:0] exp;
  } vec_t;

  vec_t vecs[12];

  localparam logic [48:0] ONE = 49'h800000000000;

  task automatic init_vecs();
    // fields: NaN inf legal sign eff_sub exp_max mant_big mant_small sticky
    vecs[0]  = '{32'h3F800000, 32'h3F800000, 1'b0, pack(0,0,1,0,0,8'h7F, ONE, ONE, 0)};
    vecs[1]  = '{32'h3F800000, 32'h30800000, 1'b0, pack(0,0,1,0,0,8'h7F, ONE, 49'h000000020000, 0)};
    vecs[2]  = '{32'h3F800000, 32'h3F800000, 1'b1, pack(0,0,1,0,1,8'h7F, ONE, ONE, 0)};
    vecs[3]  = '{32'h3F800000, 32'h40000000, 1'b1, pack(0,0,1,1,1,8'h80, ONE, 49'h400000000000, 0)};
    vecs[4]  = '{32'hBF800000, 32'h3F000000, 1'b0, pack(0,0,1,1,1,8'h7F, ONE, 49'h400000000000, 0)};
    vecs[5]  = '{32'h7F800000, 32'hFF800000, 1'b0, pack(1,0,0,0,1,8'hFF, 49'h0, 49'h0, 0)};
    vecs[6]  = '{32'h7F800000, 32'h3F800000, 1'b0, pack(0,1,0,0,0,8'hFF, 49'h0, 49'h0, 0)};
    vecs[7]  = '{32'h7FC00000, 32'h3F800000, 1'b0, pack(1,0,0,0,0,8'hFF, 49'h0, 49'h0, 0)};
    vecs[8]  = '{32'hFF800000, 32'h3F800000, 1'b0, pack(0,1,0,1,1,8'hFF, 49'h0, 49'h0, 0)};
    vecs[9]  = '{32'h00000001, 32'h00000001, 1'b0, pack(0,0,1,0,0,8'h01, 49'h000001000000, 49'h000001000000, 0)};
    vecs[10] = '{32'h3F800001, 32'h00000001, 1'b0, pack(0,0,1,0,0,8'h7F, 49'h800001000000, 49'h0, 1)};
    vecs[11] = '{32'h3F800000, 32'h33000001, 1'b0, pack(0,0,1,0,0,8'h7F, ONE, 49'h000000400000, 1)};
  endtask

  task automatic idle(input int n);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents one op, returns out_valid one edge after acceptance; on return
  // the result of that op is visible (two edges after acceptance).
  task automatic apply_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          output logic ov_mid);
    in_valid  = 1'b1;
    op_1      = a;
    op_2      = b;
    sub       = s;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    ov_mid   = out_valid;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op_1 = '0; op_2 = '0; sub = 1'b0;
    @(posedge clk);
    #1;
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    tests++;
    if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
    tests++;
    if (obs !== 112'h0) begin fails++; $display("FAIL reset_outputs got %h exp 0", obs); end
    rst_n = 1'b1;
    idle(1);
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL post_reset_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic run_range(input int lo, input int hi, input string name);
    logic mid;
    for (int i = lo; i <= hi; i++) begin
      idle(1);
      apply_op(vecs[i].a, vecs[i].b, vecs[i].s, mid);
      tests++;
      if (mid !== 1'b0 || out_valid !== 1'b1) begin
        fails++;
        $display("FAIL %s_latency vec%0d got mid=%b final=%b exp mid=0 final=1", name, i, mid, out_valid);
      end
      tests++;
      if (obs !== vecs[i].exp) begin
        fails++;
        $display("FAIL %s vec%0d got %h exp %h", name, i, obs, vecs[i].exp);
      end
    end
  endtask

  task automatic test_arith();         run_range(0, 4, "arith");   endtask
  task automatic test_specials();      run_range(5, 8, "special"); endtask
  task automatic test_denorm_sticky(); run_range(9, 11, "denorm"); endtask

  task automatic test_back_to_back();
    int acc, dlv, cyc;
    logic stalled_prev, saw_drop, a_fire, d_fire, exp_ir;
    logic [111:0] held;
    acc = 0; dlv = 0; cyc = 0;
    stalled_prev = 1'b0; saw_drop = 1'b0; held = '0;
    idle(2);
    while (dlv < 8 && cyc < 60) begin
      in_valid  = (acc < 8);
      op_1      = {1'b0, 8'(112 + acc), 23'd0};
      op_2      = op_1;
      sub       = 1'b0;
      out_ready = !(cyc >= 2 && cyc <= 4);
      @(negedge clk);
      exp_ir = !((acc - dlv) == 2 && !out_ready);
      tests++;
      if (in_ready !== exp_ir) begin
        fails++;
        $display("FAIL b2b_in_ready cyc%0d got %b exp %b", cyc, in_ready, exp_ir);
      end
      if (stalled_prev) begin
        tests++;
        if (out_valid !== 1'b1 || obs !== held) begin
          fails++;
          $display("FAIL b2b_stall_hold cyc%0d got v=%b %h exp v=1 %h", cyc, out_valid, obs, held);
        end
      end
      if (out_valid && out_ready) begin
        tests++;
        if (dlv >= acc || exp_max !== 8'(112 + dlv) || mant_big !== ONE || mant_small !== ONE) begin
          fails++;
          $display("FAIL b2b_order cyc%0d got exp_max %h exp %h", cyc, exp_max, 8'(112 + dlv));
        end
      end
      if (!in_ready) saw_drop = 1'b1;
      stalled_prev = out_valid & !out_ready;
      held   = obs;
      a_fire = in_valid & in_ready;
      d_fire = out_valid & out_ready;
      @(posedge clk);
      #1;
      acc += int'(a_fire);
      dlv += int'(d_fire);
      cyc++;
    end
    in_valid = 1'b0;
    tests++;
    if (dlv != 8 || acc != 8) begin fails++; $display("FAIL b2b_count got acc=%0d dlv=%0d exp 8/8", acc, dlv); end
    tests++;
    if (!saw_drop) begin fails++; $display("FAIL b2b_in_ready_drop got never-low exp low"); end
    idle(2);
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_no_dup got out_valid=%b exp 0", out_valid); end
  endtask

  task automatic test_reset_in_flight();
    logic mid;
    idle(2);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    op_1 = 32'h40000000; op_2 = 32'h40000000; sub = 1'b0;
    @(posedge clk);
    #1;
    op_1 = 32'h40800000; op_2 = 32'h40800000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || exp_max !== 8'h80) begin
      fails++;
      $display("FAIL rif_loaded got v=%b exp_max=%h exp v=1 exp_max=80", out_valid, exp_max);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    tests++;
    if (out_valid !== 1'b0 || obs !== 112'h0 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL rif_cleared got v=%b ir=%b %h exp v=0 ir=0 0", out_valid, in_ready, obs);
    end
    rst_n = 1'b1;
    apply_op(vecs[0].a, vecs[0].b, vecs[0].s, mid);
    tests++;
    if (mid !== 1'b0 || out_valid !== 1'b1 || obs !== vecs[0].exp) begin
      fails++;
      $display("FAIL rif_first_op got mid=%b v=%b %h exp mid=0 v=1 %h", mid, out_valid, obs, vecs[0].exp);
    end
    idle(1);
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL rif_no_stale got v=%b exp 0", out_valid); end
  endtask

  initial begin
    init_vecs();
    test_reset();
    test_arith();
    test_specials();
    test_denorm_sticky();
    test_back_to_back();
    test_reset_in_flight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
